// File: rtl/rca_seq_nb_pkg.sv
// Shared types and default parameters for the digit-serial ripple-carry adder.
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_DIGIT    = 4;
    localparam int DEF_LOA_BITS = 4;

endpackage

// File: rtl/rca_seq_nb_digit.sv
// Combinational DIGIT-bit ripple-carry slice, reused once per cycle by the top.
module rca_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic [DIGIT:0] c;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[DIGIT];
    end

endmodule

// File: rtl/rca_seq_nb.sv
// Digit-serial adder: one DIGIT-bit slice per cycle, LSB digit first.
// Optional RCA_SEQ_LOA_EN replaces the low LOA_BITS with an OR-based approximate adder.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// in_ready is combinational (IDLE, or DONE with out_ready) so DONE can hand over and capture on one edge.
module rca_seq_nb
    import rca_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DIGIT    = DEF_DIGIT,
    parameter int LOA_BITS = DEF_LOA_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             in2,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH:0]   out0,
    output logic             out_valid,
    input  logic             out_ready,
    output state_t           dbg_state
);

    localparam int NCYC = WIDTH / DIGIT;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;

    logic [DIGIT-1:0] a_dig, b_dig, s_ex, s_sel;
    logic             c_ex, c_sel;
    logic [WIDTH-1:0] sum_nx;
    logic             capture, carry_init;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign capture   = in_valid && in_ready;
    assign dbg_state = state_q;

`ifdef RCA_SEQ_LOA_EN
    localparam int LOA_DIG = LOA_BITS / DIGIT;
    assign carry_init = (LOA_DIG > 0) ? 1'b0 : in2;
`else
    assign carry_init = in2;
`endif

    always_comb begin
        a_dig = a_q[int'(cnt_q)*DIGIT +: DIGIT];
        b_dig = b_q[int'(cnt_q)*DIGIT +: DIGIT];
    end

    rca_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (a_dig),
        .b    (b_dig),
        .cin  (carry_q),
        .s    (s_ex),
        .cout (c_ex)
    );

    // Low digits become a plain OR; the top low digit's MSB AND seeds the exact part.
    always_comb begin
        s_sel = s_ex;
        c_sel = c_ex;
`ifdef RCA_SEQ_LOA_EN
        if (int'(cnt_q) < LOA_DIG) begin
            s_sel = a_dig | b_dig;
            c_sel = (int'(cnt_q) == LOA_DIG - 1) ? (a_dig[DIGIT-1] & b_dig[DIGIT-1]) : 1'b0;
        end
`endif
        sum_nx = sum_q;
        sum_nx[int'(cnt_q)*DIGIT +: DIGIT] = s_sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            out0      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    carry_q <= c_sel;
                    sum_q   <= sum_nx;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(NCYC - 1)) begin
                        out0      <= {c_sel, sum_nx};
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: ;
            endcase
            // Capture overrides the DONE->IDLE exit for zero-bubble back-to-back transfers.
            if (capture) begin
                a_q     <= in0;
                b_q     <= in1;
                carry_q <= carry_init;
                cnt_q   <= '0;
                state_q <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_rca_seq_nb.sv
// Directed bench for rca_seq_nb (WIDTH=16, DIGIT=4): vector table plus handshake/reset sequences.
module tb_rca_seq_nb;
    import rca_pkg::*;

`ifdef RCA_SEQ_LOA_EN
    localparam bit LOA = 1'b1;
`else
    localparam bit LOA = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in0 = '0, in1 = '0;
    logic        in2 = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [16:0] out0;
    state_t      dbg_state;

    int checks = 0;
    int failures = 0;

    rca_seq_nb #(.WIDTH(16), .DIGIT(4), .LOA_BITS(4)) dut (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in2(in2),
        .in_valid(in_valid), .in_ready(in_ready), .out0(out0),
        .out_valid(out_valid), .out_ready(out_ready), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [16:0] exp;
        logic [16:0] exp_loa;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [16:0] pick(input logic [16:0] exact, input logic [16:0] loa);
        return LOA ? loa : exact;
    endfunction

    // Drive operands from IDLE, scramble inputs during RUN, check 4-edge latency and sum.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [16:0] exp, input string name);
        int lat;
        @(negedge clk);
        in0 = a; in1 = b; in2 = c; in_valid = 1'b1; out_ready = 1'b0;
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in0 = 16'($urandom); in1 = 16'($urandom); in2 = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd4);
        check({name, "_sum"}, 32'(out0), 32'(exp));
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check({name, "_drain"}, 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000, 17'h0FFFF};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 17'h05556, 17'h05555};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 17'h1FFFF};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 17'h00000, 17'h00000};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 17'h00001, 17'h00000};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 17'h10000, 17'h10000};
        vecs[6] = '{16'h0FFF, 16'h0001, 1'b0, 17'h01000, 17'h00FFF};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 17'h0BE01, 17'h0BDFD};
        vecs[8] = '{16'h000F, 16'h0001, 1'b1, 17'h00011, 17'h0000F};

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out0", 32'(out0), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].c, pick(vecs[i].exp, vecs[i].exp_loa),
                  $sformatf("vec%0d", i));

        // Last value held in IDLE
        repeat (2) @(posedge clk);
        #1;
        check("idle_hold", 32'(out0), 32'(pick(17'h00011, 17'h0000F)));

        // Output stall: result and flags stay put while out_ready=0
        @(negedge clk);
        in0 = 16'h1234; in1 = 16'h4321; in2 = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("stall_valid0", 32'(out_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("stall_sum%0d", k), 32'(out0), 32'(pick(17'h05556, 17'h05555)));
            check($sformatf("stall_valid%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("stall_in_ready%0d", k), 32'(in_ready), 32'd0);
        end

        // Back-to-back: release first result and capture second on the same edge
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        in0 = 16'h7FFF; in1 = 16'h0001; in2 = 1'b0;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_state", 32'(dbg_state), 32'(RUN));
        check("b2b_valid_drop", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b2b_early", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_sum", 32'(out0), 32'(pick(17'h08000, 17'h07FFF)));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_idle", 32'(dbg_state), 32'(IDLE));

        // Reset two cycles into RUN aborts the operation
        @(negedge clk);
        in0 = 16'h1111; in1 = 16'h2222; in2 = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out0", 32'(out0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen = 0;
            repeat (6) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            check("abort_no_pulse", 32'(seen), 32'd0);
        end
        do_op(16'h0001, 16'h0001, 1'b0, pick(17'h00002, 17'h00001), "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
